hilo_ctrl: RTL and testbench

HILO_CTRL -- requirements
Module: hilo_ctrl

---
 rtl/hilo_pkg.sv | 29 ++
 rtl/hilo_fsm.sv | 65 ++++++
 rtl/hilo_ctrl.sv | 120 ++++++++++++
 tb/tb_hilo_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO control block: funct codes, FSM state type,
// default divider latency, and the HI/LO opcode decode helper.
// Optional feature macro: HILO_MTHI_MTLO_EN (MTHI/MTLO recognised when defined).
package hilo_pkg;

    localparam int DIV_LATENCY_DEF = 34;

    localparam logic [5:0] FN_MFHI = 6'b010000;
    localparam logic [5:0] FN_MTHI = 6'b010001;
    localparam logic [5:0] FN_MFLO = 6'b010010;
    localparam logic [5:0] FN_MTLO = 6'b010011;
    localparam logic [5:0] FN_DIVU = 6'b011011;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } hilo_state_e;

    // True for every funct this block owns; only these can be stalled.
    function automatic logic is_hilo_op(input logic [5:0] f);
        logic hit;
        hit = (f == FN_MFHI) || (f == FN_MFLO) || (f == FN_DIVU);
`ifdef HILO_MTHI_MTLO_EN
        hit = hit || (f == FN_MTHI) || (f == FN_MTLO);
`endif
        return hit;
    endfunction

endpackage

// File: rtl/hilo_fsm.sv
// Divide sequencer: IDLE/BUSY state, latency counter and divider load pulse.
// Latency: busy for DIV_LATENCY cycles after start_i; done_o in the last one.
// Backpressure: none internally; the top stalls HI/LO ops while busy_o is high.
// Ports: clk, reset (sync, active-high), start_i (accepted non-zero DIVU),
//        busy_o, div_start_o (first BUSY cycle), done_o (comb, last BUSY cycle).
module hilo_fsm
    import hilo_pkg::*;
#(
    parameter int DIV_LATENCY = DIV_LATENCY_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic start_i,
    output logic busy_o,
    output logic div_start_o,
    output logic done_o
);

    localparam int CW = $clog2(DIV_LATENCY + 1);

    hilo_state_e    state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           div_start_q, div_start_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            div_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            div_start_q <= div_start_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        div_start_d = 1'b0;
        done_o      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d     = ST_BUSY;
                    cnt_d       = CW'(DIV_LATENCY);
                    div_start_d = 1'b1;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - CW'(1);
                // Counter value 1 marks the final BUSY cycle: result is valid now.
                if (cnt_q == CW'(1)) begin
                    done_o  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy_o      = (state_q == ST_BUSY);
    assign div_start_o = div_start_q;

endmodule

// File: rtl/hilo_ctrl.sv
// HI/LO register control: sequences an external DIVU divider, holds HI/LO, serves MFHI/MFLO.
// Latency: MF* result one cycle after accept; DIVU result in HI/LO after DIV_LATENCY cycles.
// Backpressure: stall (comb) holds any HI/LO op while a divide is in flight; others pass.
// Ports: clk, reset (sync, active-high), valid_in/funct/rs_data/rt_data (instruction),
//        stall, busy, div_start/div_dividend/div_divisor/div_result (divider link),
//        rd_data/rd_valid (MF* read), div_zero (DIVU by zero pulse).
// Optional feature macro: HILO_MTHI_MTLO_EN enables MTHI/MTLO writes.
module hilo_ctrl
    import hilo_pkg::*;
#(
    parameter int DIV_LATENCY = DIV_LATENCY_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic [5:0]  funct,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        stall,
    output logic        div_start,
    output logic [31:0] div_dividend,
    output logic [31:0] div_divisor,
    input  logic [63:0] div_result,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic        div_zero,
    output logic        busy
);

    logic        accept;
    logic        divu_acc;
    logic        div_go;
    logic        div_done;

    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] dvd_q, dvd_d;
    logic [31:0] dvs_q, dvs_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        rd_valid_q, rd_valid_d;
    logic        div_zero_q, div_zero_d;

    assign stall    = busy & valid_in & is_hilo_op(funct);
    assign accept   = valid_in & ~stall;
    assign divu_acc = accept & (funct == FN_DIVU);
    // DIVU is stalled while busy, so a start can only arrive in IDLE.
    assign div_go   = divu_acc & (rt_data != 32'd0);

    hilo_fsm #(
        .DIV_LATENCY (DIV_LATENCY)
    ) u_fsm (
        .clk         (clk),
        .reset       (reset),
        .start_i     (div_go),
        .busy_o      (busy),
        .div_start_o (div_start),
        .done_o      (div_done)
    );

    always_comb begin
        hi_d       = hi_q;
        lo_d       = lo_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        div_zero_d = divu_acc & (rt_data == 32'd0);

        if (div_go) begin
            dvd_d = rs_data;
            dvs_d = rt_data;
        end

        if (div_done) begin
            hi_d = div_result[63:32];
            lo_d = div_result[31:0];
        end

`ifdef HILO_MTHI_MTLO_EN
        // MT* are stalled while busy, so they never collide with div_done.
        if (accept && funct == FN_MTHI) hi_d = rs_data;
        if (accept && funct == FN_MTLO) lo_d = rs_data;
`endif

        if (accept && funct == FN_MFHI) begin
            rd_data_d  = hi_q;
            rd_valid_d = 1'b1;
        end else if (accept && funct == FN_MFLO) begin
            rd_data_d  = lo_q;
            rd_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q       <= '0;
            lo_q       <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign div_dividend = dvd_q;
    assign div_divisor  = dvs_q;
    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;
    assign div_zero     = div_zero_q;

endmodule

// File: tb/tb_hilo_ctrl.sv
// Self-checking bench for hilo_ctrl: reset state, divide sequencing with a stalled
// MFLO, table of single-cycle IDLE operations, and reset abort of a running divide.
module tb_hilo_ctrl;
    import hilo_pkg::*;

    localparam int LAT = 34;

`ifdef HILO_MTHI_MTLO_EN
    localparam logic [31:0] EXP_HI_MT = 32'hDEADBEEF;
    localparam logic [31:0] EXP_LO_MT = 32'h12345678;
`else
    localparam logic [31:0] EXP_HI_MT = 32'd2;
    localparam logic [31:0] EXP_LO_MT = 32'd14;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    logic [5:0]  funct;
    logic [31:0] rs_data, rt_data;
    logic        stall, div_start, rd_valid, div_zero, busy;
    logic [31:0] div_dividend, div_divisor, rd_data;
    logic [63:0] div_result;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Behavioural external divider fed by the latched operands.
    assign div_result = (div_divisor != 32'd0) ?
                        {div_dividend % div_divisor, div_dividend / div_divisor} : 64'd0;

    hilo_ctrl #(.DIV_LATENCY(LAT)) dut (
        .clk          (clk),
        .reset        (reset),
        .valid_in     (valid_in),
        .funct        (funct),
        .rs_data      (rs_data),
        .rt_data      (rt_data),
        .stall        (stall),
        .div_start    (div_start),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_result   (div_result),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .div_zero     (div_zero),
        .busy         (busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Issue one MF* in IDLE and check the registered read one cycle later.
    task automatic do_mf(input string name, input logic [5:0] f, input logic [31:0] exp);
        @(negedge clk);
        valid_in = 1'b1;
        funct    = f;
        @(negedge clk);
        valid_in = 1'b0;
        #1;
        chk({name, "_vld"}, 64'(rd_valid), 64'd1);
        chk({name, "_dat"}, 64'(rd_data), 64'(exp));
    endtask

    typedef struct {
        logic        vld;
        logic [5:0]  fn;
        logic [31:0] rs;
        logic [31:0] rt;
        logic        e_stall;
        logic        e_rdv;
        logic [31:0] e_rd;
        logic        e_dz;
        logic        e_busy;
    } vec_t;

    vec_t vec [10];

    int busy_cnt, start_cnt, stall_bad, rdv_busy;

    initial begin
        // HI=2, LO=14 are in place when the table runs (after the 100/7 divide).
        vec[0] = '{1'b1, FN_MFHI,      32'd0,         32'd0, 1'b0, 1'b1, 32'd2,     1'b0, 1'b0};
        vec[1] = '{1'b0, FN_MFLO,      32'd0,         32'd0, 1'b0, 1'b0, 32'd2,     1'b0, 1'b0};
        vec[2] = '{1'b1, FN_DIVU,      32'd5,         32'd0, 1'b0, 1'b0, 32'd2,     1'b1, 1'b0};
        vec[3] = '{1'b1, FN_MFLO,      32'd0,         32'd0, 1'b0, 1'b1, 32'd14,    1'b0, 1'b0};
        vec[4] = '{1'b1, 6'b100000,    32'd99,        32'd1, 1'b0, 1'b0, 32'd14,    1'b0, 1'b0};
        vec[5] = '{1'b1, FN_MTHI,      32'hDEADBEEF,  32'd0, 1'b0, 1'b0, 32'd14,    1'b0, 1'b0};
        vec[6] = '{1'b1, FN_MFHI,      32'd0,         32'd0, 1'b0, 1'b1, EXP_HI_MT, 1'b0, 1'b0};
        vec[7] = '{1'b1, FN_MTLO,      32'h12345678,  32'd0, 1'b0, 1'b0, EXP_HI_MT, 1'b0, 1'b0};
        vec[8] = '{1'b1, FN_MFLO,      32'd0,         32'd0, 1'b0, 1'b1, EXP_LO_MT, 1'b0, 1'b0};
        vec[9] = '{1'b1, FN_MFHI,      32'd0,         32'd0, 1'b0, 1'b1, EXP_HI_MT, 1'b0, 1'b0};

        reset    = 1'b1;
        valid_in = 1'b0;
        funct    = 6'd0;
        rs_data  = 32'd0;
        rt_data  = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_busy",     64'(busy),         64'd0);
        chk("rst_rd_valid", 64'(rd_valid),     64'd0);
        chk("rst_rd_data",  64'(rd_data),      64'd0);
        chk("rst_start",    64'(div_start),    64'd0);
        chk("rst_dz",       64'(div_zero),     64'd0);
        chk("rst_dvd",      64'(div_dividend), 64'd0);
        chk("rst_dvs",      64'(div_divisor),  64'd0);
        do_mf("rst_hi", FN_MFHI, 32'd0);

        // DIVU 100/7 with an MFLO arriving on the third BUSY cycle and held.
        @(negedge clk);
        valid_in = 1'b1; funct = FN_DIVU; rs_data = 32'd100; rt_data = 32'd7;
        @(negedge clk);
        valid_in = 1'b0;
        busy_cnt = 0; start_cnt = 0; stall_bad = 0; rdv_busy = 0;
        for (int c = 0; c < 200; c++) begin
            #1;
            if (!busy) break;
            busy_cnt++;
            if (div_start) start_cnt++;
            if (rd_valid) rdv_busy++;
            if (valid_in && !stall) stall_bad++;
            if (busy_cnt == 1) begin
                chk("div_start_first", 64'(div_start),    64'd1);
                chk("latch_dvd",       64'(div_dividend), 64'd100);
                chk("latch_dvs",       64'(div_divisor),  64'd7);
            end
            if (busy_cnt == 3) begin
                valid_in = 1'b1;
                funct    = FN_MFLO;
            end
            @(negedge clk);
        end
        chk("busy_cycles",   64'(busy_cnt),  64'(LAT));
        chk("start_pulses",  64'(start_cnt), 64'd1);
        chk("mf_stalled",    64'(stall_bad), 64'd0);
        chk("no_rdv_busy",   64'(rdv_busy),  64'd0);
        chk("idle_no_stall", 64'(stall),     64'd0);
        @(negedge clk);
        valid_in = 1'b0;
        #1;
        chk("mflo_after_vld", 64'(rd_valid), 64'd1);
        chk("mflo_after_dat", 64'(rd_data),  64'd14);
        do_mf("divu_hi", FN_MFHI, 32'd2);

        // Single-cycle IDLE operations.
        foreach (vec[i]) begin
            @(negedge clk);
            valid_in = vec[i].vld;
            funct    = vec[i].fn;
            rs_data  = vec[i].rs;
            rt_data  = vec[i].rt;
            #1;
            chk($sformatf("v%0d_stall", i), 64'(stall), 64'(vec[i].e_stall));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_rdv", i),  64'(rd_valid), 64'(vec[i].e_rdv));
            chk($sformatf("v%0d_rd", i),   64'(rd_data),  64'(vec[i].e_rd));
            chk($sformatf("v%0d_dz", i),   64'(div_zero), 64'(vec[i].e_dz));
            chk($sformatf("v%0d_busy", i), 64'(busy),     64'(vec[i].e_busy));
        end
        @(negedge clk);
        valid_in = 1'b0;
        #1;
        chk("dz_one_pulse_end", 64'(div_zero), 64'd0);

        // DIVU 0xFFFFFFFF/3, foreign op mid-divide, reset on BUSY cycle 10.
        @(negedge clk);
        valid_in = 1'b1; funct = FN_DIVU; rs_data = 32'hFFFFFFFF; rt_data = 32'd3;
        @(negedge clk);
        valid_in = 1'b0;
        repeat (4) @(negedge clk);
        valid_in = 1'b1; funct = 6'b100000;
        #1;
        chk("foreign_busy",  64'(busy),  64'd1);
        chk("foreign_stall", 64'(stall), 64'd0);
        @(negedge clk);
        valid_in = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("pre_reset_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort_busy",  64'(busy),         64'd0);
        chk("abort_dvd",   64'(div_dividend), 64'd0);
        chk("abort_dvs",   64'(div_divisor),  64'd0);
        chk("abort_start", 64'(div_start),    64'd0);
        repeat (LAT + 10) @(negedge clk);
        #1;
        chk("abort_idle", 64'(busy), 64'd0);
        do_mf("abort_hi", FN_MFHI, 32'd0);
        do_mf("abort_lo", FN_MFLO, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
